ssf: RTL and testbench



---
 rtl/ssf.sv | 94 +++++++++
 tb/tb_ssf.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ssf.sv
// Sum-of-squares filter core: takes N_SAMP signed samples per frame from a shared bus and
// publishes sum(x^2) >> SHIFT, saturated to the positive 32-bit signed range.
module ssf #(
  parameter int N_SAMP = 1024,
  parameter int SHIFT  = 10,
  parameter int GAP    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] io_in,
  output logic signed [31:0] io_out,
  output logic [1:0]         req_in,
  output logic [1:0]         out_en
);

  // Handshake: no back-pressure. req_in == 2'b01 means io_in is consumed at the end of
  // this cycle; out_en == 2'b01 marks the single cycle in which a new io_out is presented.
  localparam int CW = $clog2(N_SAMP + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] LAST_SAMP = CW'(N_SAMP - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_START,
    S_ACQ,
    S_CALC,
    S_OUT,
    S_GAP
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [CW-1:0]      count;
  logic [GW-1:0]      gap_cnt;
  logic [73:0]        acc;
  logic signed [63:0] sq;
  logic [73:0]        scaled;
  logic               sat;

  // Both operands signed, so the 64-bit product is the true square (never negative).
  assign sq     = io_in * io_in;
  assign scaled = acc >> SHIFT;
  assign sat    = |scaled[73:31];

  always_ff @(posedge clk) begin
    if (rst) state <= S_START;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req_in   = 2'b00;
    out_en   = 2'b00;
    case (state)
      S_START: state_nx = S_ACQ;
      S_ACQ: begin
        req_in = 2'b01;
        if (count == LAST_SAMP) state_nx = S_CALC;
      end
      S_CALC: state_nx = S_OUT;
      S_OUT: begin
        out_en   = 2'b01;
        state_nx = (GAP > 0) ? S_GAP : S_START;
      end
      S_GAP: if (gap_cnt == LAST_GAP) state_nx = S_START;
      default: state_nx = S_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      count   <= '0;
      gap_cnt <= '0;
      io_out  <= '0;
    end else begin
      case (state)
        S_START: begin
          acc   <= '0;
          count <= '0;
        end
        S_ACQ: begin
          acc   <= acc + {10'd0, sq};
          count <= count + 1'b1;
        end
        S_CALC:  io_out  <= sat ? 32'sh7FFF_FFFF : $signed(scaled[31:0]);
        S_OUT:   gap_cnt <= '0;
        S_GAP:   gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ssf.sv
// Bench for ssf: four cores on one shared io_in bus, each with its own reset, checked every
// cycle against a frame-position model with an expected-result queue per core.
module tb_ssf;

  localparam int NI   = 4;
  localparam int N    = 4;
  localparam int NCYC = 220;

  logic              clk;
  logic [NI-1:0]     rst_v;
  logic [31:0]       io_in;
  logic [31:0]       io_out_w [NI];
  logic [1:0]        req_w    [NI];
  logic [1:0]        out_w    [NI];

  int shift_c [NI] = '{0, 2, 0, 0};
  int gap_c   [NI] = '{0, 0, 5, 0};
  int rel_c   [NI] = '{3, 3, 3, 6};

  int          f        [NI];
  logic [73:0] macc     [NI];
  logic [31:0] last_res [NI];
  int          nres     [NI];
  int          last_out_cyc [NI];
  logic [31:0] exp_q    [NI][$];

  int n_checks;
  int n_err;
  int cyc;
  bit aborted;

  ssf #(.N_SAMP(N), .SHIFT(0), .GAP(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .io_in(io_in), .io_out(io_out_w[0]),
    .req_in(req_w[0]), .out_en(out_w[0]));
  ssf #(.N_SAMP(N), .SHIFT(2), .GAP(0)) u1 (
    .clk(clk), .rst(rst_v[1]), .io_in(io_in), .io_out(io_out_w[1]),
    .req_in(req_w[1]), .out_en(out_w[1]));
  ssf #(.N_SAMP(N), .SHIFT(0), .GAP(5)) u2 (
    .clk(clk), .rst(rst_v[2]), .io_in(io_in), .io_out(io_out_w[2]),
    .req_in(req_w[2]), .out_en(out_w[2]));
  ssf #(.N_SAMP(N), .SHIFT(0), .GAP(0)) u3 (
    .clk(clk), .rst(rst_v[3]), .io_in(io_in), .io_out(io_out_w[3]),
    .req_in(req_w[3]), .out_en(out_w[3]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_res(input logic [73:0] a, input int sh);
    logic [73:0] r;
    r = a >> sh;
    if (r > 74'h0_7FFF_FFFF) return 32'h7FFF_FFFF;
    return r[31:0];
  endfunction

  // Directed sample for the first four frames of core 0; random afterwards.
  function automatic logic [31:0] pick_sample(input int frame, input int pos);
    logic [31:0] v;
    case (frame)
      0:       v = 32'(pos);
      1:       v = -32'sd3;
      2:       v = 32'h8000_0000;
      3:       v = 32'd2;
      default: v = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom_range(0, 2000) - 32'd1000);
    endcase
    return v;
  endfunction

  task automatic step();
    logic [1:0]  exp_req;
    logic [1:0]  exp_out;
    logic [63:0] sq;
    longint      sv;
    int          per;
    // frame position of each core in this cycle
    for (int i = 0; i < NI; i++) begin
      per = N + gap_c[i] + 3;
      if (rst_v[i]) begin
        f[i]        = 0;
        last_res[i] = '0;
        exp_q[i].delete();
      end else begin
        f[i] = (f[i] + 1) % per;
      end
      if (f[i] == 0) macc[i] = '0;
    end
    // driver: value consumed at the coming rising edge
    if (f[0] >= 1 && f[0] <= N) io_in = pick_sample(nres[0], f[0]);
    else                        io_in = $urandom;
    sv = longint'($signed(io_in));
    sq = sv * sv;
    for (int i = 0; i < NI; i++) begin
      if (f[i] >= 1 && f[i] <= N) macc[i] = macc[i] + {10'd0, sq};
      if (f[i] == N + 1) exp_q[i].push_back(sat_res(macc[i], shift_c[i]));
      if (f[i] == N + 2) begin
        if (exp_q[i].size() == 0) check($sformatf("queue_empty%0d", i), 32'd1, 32'd0);
        else                      last_res[i] = exp_q[i].pop_front();
        if (i == 0 && nres[0] == 0) check("dir_sum30", io_out_w[0], 32'd30);
        if (i == 0 && nres[0] == 1) check("dir_neg36", io_out_w[0], 32'd36);
        if (i == 0 && nres[0] == 2) check("dir_sat", io_out_w[0], 32'h7FFF_FFFF);
        if (i == 1 && nres[1] == 3) check("dir_shift4", io_out_w[1], 32'd4);
        nres[i]++;
      end
      exp_req = (f[i] >= 1 && f[i] <= N) ? 2'b01 : 2'b00;
      exp_out = (f[i] == N + 2) ? 2'b01 : 2'b00;
      check($sformatf("req_in%0d", i), 32'(req_w[i]), 32'(exp_req));
      check($sformatf("out_en%0d", i), 32'(out_w[i]), 32'(exp_out));
      check($sformatf("io_out%0d", i), io_out_w[i], last_res[i]);
    end
    check("no_overlap", 32'(out_w[0] == 2'b01 && out_w[3] == 2'b01), 32'd0);
    if (out_w[2] == 2'b01) begin
      if (last_out_cyc[2] >= 0) check("gap_period", 32'(cyc - last_out_cyc[2]), 32'd12);
      last_out_cyc[2] = cyc;
    end
    // reset schedule: staggered release, then abort core 0 after two samples of frame 6
    for (int i = 0; i < NI; i++) rst_v[i] = (cyc + 1 < rel_c[i]);
    if (!aborted && nres[0] == 6 && f[0] == 3) begin
      rst_v[0] = 1'b1;
      aborted  = 1'b1;
    end
  endtask

  initial begin
    rst_v    = '1;
    io_in    = '0;
    n_checks = 0;
    n_err    = 0;
    aborted  = 1'b0;
    for (int i = 0; i < NI; i++) begin
      f[i]            = 0;
      macc[i]         = '0;
      last_res[i]     = '0;
      nres[i]         = 0;
      last_out_cyc[i] = -1;
    end
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cyc = c;
      step();
    end
    check("aborted_done", 32'(aborted), 32'd1);
    check("frames_core2", 32'(nres[2] >= 10), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
